// File: rtl/mips_run_monitor_pkg.sv
// Shared types and constants for the MIPS run monitor.
package mips_mon_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NOP     = 2'd1,
    TIMEOUT = 2'd2
  } halt_cause_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } mon_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Observation bus between the core (master) and the run monitor (slave).
interface mips_run_monitor_if #(parameter int TRACE_DEPTH = 8);
  localparam int IDX_W = $clog2(TRACE_DEPTH);

  logic             instr_valid;
  logic [31:0]      instr;
  logic [31:0]      alu_result;
  logic             halt;
  logic [1:0]       halt_cause;
  logic [31:0]      cycle_count;
  logic [31:0]      instr_count;
  logic [7:0]       nop_run;
  logic [31:0]      last_result;
  logic [IDX_W-1:0] trace_rd_idx;
  logic [31:0]      trace_rd_data;
  logic [IDX_W:0]   trace_count;

  modport master (
    output instr_valid, instr, alu_result, trace_rd_idx,
    input  halt, halt_cause, cycle_count, instr_count, nop_run,
           last_result, trace_rd_data, trace_count
  );

  modport slave (
    input  instr_valid, instr, alu_result, trace_rd_idx,
    output halt, halt_cause, cycle_count, instr_count, nop_run,
           last_result, trace_rd_data, trace_count
  );
endinterface

// File: rtl/mips_trace_ring.sv
// Ring buffer of recent instruction words: push, newest-first indexed read,
// saturating valid-entry count. DEPTH must be a power of 2.
module mips_trace_ring #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [IDX_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W-1:0] rd_addr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q != (IDX_W+1)'(DEPTH))
        count_d = count_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are hidden by count_q.
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_addr = wr_ptr_q - IDX_W'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < count_q) ? mem_q[rd_addr] : '0;
  assign count   = count_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor: NOP-run end-of-program detection, timeout, counters and an
// optional instruction trace ring (built only when MIPS_MON_TRACE_EN is defined).
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int NOP_LIMIT      = 4,
  parameter int DRAIN_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TRACE_DEPTH    = 8
) (
  input logic              clk,
  input logic              reset,
  mips_run_monitor_if.slave mon
);

  localparam int          IDX_W       = $clog2(TRACE_DEPTH);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  mon_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic        halt_q, halt_d;
  logic [7:0]  drain_q, drain_d;
  logic [7:0]  nop_q, nop_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] last_q, last_d;

  logic in_run, is_nop, is_instr, nop_limit_hit, timeout_hit, active, push;

  assign in_run        = (state_q == RUN);
  assign is_nop        = in_run && mon.instr_valid && (mon.instr == MIPS_NOP);
  assign is_instr      = in_run && mon.instr_valid && (mon.instr != MIPS_NOP);
  assign nop_limit_hit = is_nop && (nop_q != 8'hFF) && (int'(nop_q) + 1 == NOP_LIMIT);
  // A NOP-limit hit in the timeout cycle takes the NOP path instead.
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && in_run && (cycle_q >= TIMEOUT_LIM)
                         && !nop_limit_hit;
  assign active        = in_run && !timeout_hit;
  assign push          = active && is_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cause_q  <= NONE;
      halt_q   <= 1'b0;
      drain_q  <= '0;
      nop_q    <= '0;
      cycle_q  <= '0;
      icount_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      halt_q   <= halt_d;
      drain_q  <= drain_d;
      nop_q    <= nop_d;
      cycle_q  <= cycle_d;
      icount_q <= icount_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (nop_limit_hit) begin
          drain_d = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d = HALTED;
            cause_d = NOP;
          end else begin
            state_d = DRAIN;
          end
        end else if (timeout_hit) begin
          state_d = HALTED;
          cause_d = TIMEOUT;
        end
      end
      DRAIN: begin
        if (int'(drain_q) + 1 >= DRAIN_CYCLES) begin
          state_d = HALTED;
          cause_d = NOP;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // halt trails the HALTED state by one edge.
  always_comb begin
    halt_d   = (state_q == HALTED);
    cycle_d  = cycle_q;
    nop_d    = nop_q;
    icount_d = icount_q;
    last_d   = last_q;
    if (active || state_q == DRAIN)
      cycle_d = sat_inc32(cycle_q);
    if (active && is_nop && nop_q != 8'hFF)
      nop_d = nop_q + 8'd1;
    if (push) begin
      nop_d    = '0;
      icount_d = sat_inc32(icount_q);
      last_d   = mon.alu_result;
    end
  end

  assign mon.halt        = halt_q;
  assign mon.halt_cause  = cause_q;
  assign mon.cycle_count = cycle_q;
  assign mon.instr_count = icount_q;
  assign mon.nop_run     = nop_q;
  assign mon.last_result = last_q;

`ifdef MIPS_MON_TRACE_EN
  mips_trace_ring #(
    .DEPTH(TRACE_DEPTH),
    .WIDTH(32)
  ) u_trace_ring (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(mon.instr),
    .rd_idx   (mon.trace_rd_idx),
    .rd_data  (mon.trace_rd_data),
    .count    (mon.trace_count)
  );
`else
  logic             unused_push;
  logic [IDX_W-1:0] unused_trace_idx;
  assign unused_push       = push;
  assign unused_trace_idx  = mon.trace_rd_idx;
  assign mon.trace_rd_data = '0;
  assign mon.trace_count   = '0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed self-checking bench for mips_run_monitor: default build on dutA,
// timeout / shallow-trace / zero-drain build on dutB.
module tb_mips_run_monitor;
  import mips_mon_pkg::*;

`ifdef MIPS_MON_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic clk;
  logic resetA, resetB;
  int   errors;
  int   checks;

  mips_run_monitor_if #(.TRACE_DEPTH(8)) ifA ();
  mips_run_monitor_if #(.TRACE_DEPTH(4)) ifB ();

  mips_run_monitor dutA (
    .clk  (clk),
    .reset(resetA),
    .mon  (ifA.slave)
  );

  mips_run_monitor #(
    .NOP_LIMIT     (4),
    .DRAIN_CYCLES  (0),
    .TIMEOUT_CYCLES(16),
    .TRACE_DEPTH   (4)
  ) dutB (
    .clk  (clk),
    .reset(resetB),
    .mon  (ifB.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] trExp(input logic [31:0] v);
    return TRACE_ON ? v : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the selected DUT, then sample 1 time unit after the edge.
  task automatic applyStimulus(input bit selB, input logic v, input logic [31:0] w,
                               input logic [31:0] alu);
    if (selB) begin
      ifB.instr_valid = v; ifB.instr = w; ifB.alu_result = alu;
    end else begin
      ifA.instr_valid = v; ifA.instr = w; ifA.alu_result = alu;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input bit selB);
    if (selB) resetB = 1'b1; else resetA = 1'b1;
    applyStimulus(selB, 1'b0, 32'h0, 32'h0);
    if (selB) resetB = 1'b0; else resetA = 1'b0;
  endtask

  task automatic checkReadA(input string tag, input int idx, input logic [31:0] expected);
    ifA.trace_rd_idx = 3'(idx);
    #1;
    checkOutput(tag, ifA.trace_rd_data, expected);
  endtask

  task automatic checkReadB(input string tag, input int idx, input logic [31:0] expected);
    ifB.trace_rd_idx = 2'(idx);
    #1;
    checkOutput(tag, ifB.trace_rd_data, expected);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    resetA = 1'b1;
    resetB = 1'b1;
    ifA.instr_valid = 1'b0; ifA.instr = '0; ifA.alu_result = '0; ifA.trace_rd_idx = '0;
    ifB.instr_valid = 1'b0; ifB.instr = '0; ifB.alu_result = '0; ifB.trace_rd_idx = '0;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_halt",   32'(ifA.halt),        32'd0);
    checkOutput("rst_cause",  32'(ifA.halt_cause),  32'd0);
    checkOutput("rst_cycle",  ifA.cycle_count,      32'd0);
    checkOutput("rst_icount", ifA.instr_count,      32'd0);
    checkOutput("rst_nop",    32'(ifA.nop_run),     32'd0);
    checkOutput("rst_last",   ifA.last_result,      32'd0);
    checkOutput("rst_tcount", 32'(ifA.trace_count), 32'd0);
    resetA = 1'b0;
    resetB = 1'b0;

    // Two instructions then four NOPs, default parameters
    applyStimulus(0, 1'b1, 32'h200A000A, 32'h0000_000A);
    applyStimulus(0, 1'b1, 32'h200C000B, 32'h0000_000B);
    checkOutput("p1_icount", ifA.instr_count, 32'd2);
    checkOutput("p1_last",   ifA.last_result, 32'h0000_000B);
    checkOutput("p1_cycle",  ifA.cycle_count, 32'd2);
    checkReadA("p1_tr0", 0, trExp(32'h200C000B));
    checkReadA("p1_tr1", 1, trExp(32'h200A000A));
    checkReadA("p1_tr2_empty", 2, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p1_nop3",  32'(ifA.nop_run), 32'd3);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p1_nop4",  32'(ifA.nop_run), 32'd4);
    checkOutput("p1_halt_e0", 32'(ifA.halt), 32'd0);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p1_halt_e1", 32'(ifA.halt), 32'd0);
    applyStimulus(0, 1'b0, 32'h1111_1111, 32'h0);
    checkOutput("p1_halt_e2", 32'(ifA.halt),       32'd1);
    checkOutput("p1_cause",   32'(ifA.halt_cause), 32'd1);
    checkOutput("p1_cycle_h", ifA.cycle_count,     32'd7);
    applyStimulus(0, 1'b1, 32'h2222_2222, 32'h0000_0099);
    checkOutput("p1_icount_frz", ifA.instr_count, 32'd2);
    checkOutput("p1_last_frz",   ifA.last_result, 32'h0000_000B);
    checkOutput("p1_cycle_frz",  ifA.cycle_count, 32'd7);
    checkOutput("p1_halt_stk",   32'(ifA.halt),   32'd1);
    checkReadA("p1_tr0_frz", 0, trExp(32'h200C000B));

    // NOP run broken by an instruction; idle cycle inside the final run
    resetDut(0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p2_nop3",  32'(ifA.nop_run), 32'd3);
    checkOutput("p2_nohalt", 32'(ifA.halt),   32'd0);
    applyStimulus(0, 1'b1, 32'h018A5820, 32'h0000_0033);
    checkOutput("p2_nop_clr", 32'(ifA.nop_run), 32'd0);
    checkOutput("p2_last",    ifA.last_result,  32'h0000_0033);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    checkOutput("p2_idle_hold", 32'(ifA.nop_run), 32'd2);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p2_nop4", 32'(ifA.nop_run), 32'd4);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    checkOutput("p2_halt_e1", 32'(ifA.halt), 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    checkOutput("p2_halt_e2", 32'(ifA.halt),       32'd1);
    checkOutput("p2_cause",   32'(ifA.halt_cause), 32'd1);
    checkOutput("p2_icount",  ifA.instr_count,     32'd1);
    checkOutput("p2_cycle",   ifA.cycle_count,     32'd10);
    checkOutput("p2_tcount",  32'(ifA.trace_count), trExp(32'd1));
    checkReadA("p2_tr0", 0, trExp(32'h018A5820));
    checkReadA("p2_tr1_empty", 1, 32'h0);

    // Reset during DRAIN, then a fresh NOP run
    resetDut(0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 32'h0, 32'h0);
    checkOutput("p5_nop4", 32'(ifA.nop_run), 32'd4);
    checkOutput("p5_cycle_pre", ifA.cycle_count, 32'd4);
    resetDut(0);
    checkOutput("p5_halt",   32'(ifA.halt),       32'd0);
    checkOutput("p5_cause",  32'(ifA.halt_cause), 32'd0);
    checkOutput("p5_cycle",  ifA.cycle_count,     32'd0);
    checkOutput("p5_nop",    32'(ifA.nop_run),    32'd0);
    checkOutput("p5_icount", ifA.instr_count,     32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    checkOutput("p5_nop3_hold", 32'(ifA.nop_run), 32'd3);
    checkOutput("p5_nohalt",    32'(ifA.halt),    32'd0);
    applyStimulus(0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    checkOutput("p5_halt_end",  32'(ifA.halt),       32'd1);
    checkOutput("p5_cause_end", 32'(ifA.halt_cause), 32'd1);

    // Shallow ring wrap, then timeout with continuous instructions
    resetDut(1);
    for (int k = 1; k <= 6; k++) applyStimulus(1, 1'b1, 32'(k), 32'(k * 3));
    checkOutput("p4_tcount", 32'(ifB.trace_count), trExp(32'd4));
    checkReadB("p4_tr0", 0, trExp(32'd6));
    checkReadB("p4_tr1", 1, trExp(32'd5));
    checkReadB("p4_tr2", 2, trExp(32'd4));
    checkReadB("p4_tr3", 3, trExp(32'd3));
    checkOutput("p4_last", ifB.last_result, 32'd18);
    for (int k = 7; k <= 16; k++) applyStimulus(1, 1'b1, 32'(k), 32'(k * 3));
    checkOutput("p3_cycle16",  ifB.cycle_count, 32'd16);
    checkOutput("p3_icount16", ifB.instr_count, 32'd16);
    checkOutput("p3_nohalt",   32'(ifB.halt),   32'd0);
    applyStimulus(1, 1'b1, 32'd17, 32'd51);
    checkOutput("p3_cause_ent", 32'(ifB.halt_cause), 32'd2);
    checkOutput("p3_halt_e1",   32'(ifB.halt),       32'd0);
    applyStimulus(1, 1'b1, 32'd18, 32'd54);
    checkOutput("p3_halt",   32'(ifB.halt),       32'd1);
    checkOutput("p3_cause",  32'(ifB.halt_cause), 32'd2);
    checkOutput("p3_cycle",  ifB.cycle_count,     32'd16);
    checkOutput("p3_icount", ifB.instr_count,     32'd16);
    checkOutput("p3_last",   ifB.last_result,     32'd48);
    checkReadB("p3_tr0", 0, trExp(32'd16));

    // Zero drain cycles: halt one edge after the limiting NOP
    resetDut(1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 32'h0, 32'h0);
    checkOutput("d0_halt_e0", 32'(ifB.halt),       32'd0);
    checkOutput("d0_cause",   32'(ifB.halt_cause), 32'd1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0);
    checkOutput("d0_halt_e1", 32'(ifB.halt),       32'd1);
    checkOutput("d0_cycle",   ifB.cycle_count,     32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
